pulse_trigger_processor: RTL and testbench

- Consumer end of the Pulse Trigger FIFO. Pops one 128-bit trigger-info word per front-panel trigger and checks trigger-number continuity.
- Waits for every enabled channel to report acquisition done.
- Emits a two-beat 64-bit trigger record to the readout FIFO, used by the command manager when building asynchronous-mode event payloads.

---
 rtl/pulse_trigger_processor.sv | 194 +++++++++++++++++++
 tb/tb_pulse_trigger_processor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_trigger_processor.sv
// Pulse Trigger FIFO consumer: pops trigger info, waits for enabled channels, emits a 2-beat record.
// Optional WAIT_CHAN timeout is compiled in with `define PULSE_TRIG_PROC_TIMEOUT_EN.
module pulse_trigger_processor #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4095
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reset_trig_num,
  input  logic         readout_done,
  input  logic [4:0]   chan_en,
  input  logic         trig_fifo_valid,
  input  logic [127:0] trig_fifo_data,
  output logic         trig_fifo_ready,
  input  logic [4:0]   chan_done,
  output logic         info_valid,
  input  logic         info_ready,
  output logic [63:0]  info_data,
  output logic         info_last,
  output logic [4:0]   state,
  output logic [31:0]  seq_error_count,
  output logic [31:0]  timeout_count,
  output logic [23:0]  processed_count
);

  typedef enum logic [4:0] {
    StIdle     = 5'b00001,
    StWaitChan = 5'b00010,
    StSendHdr  = 5'b00100,
    StSendTail = 5'b01000,
    StDrain    = 5'b10000
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   len_q;
  logic [23:0]  num_q;
  logic [43:0]  ts_q;
  logic [4:0]   en_q;
  logic [4:0]   done_mask_q;
  logic         seq_err_q;
  logic         timeout_q;
  logic [23:0]  expected_num_q;
  logic [31:0]  seq_error_count_q;
  logic [23:0]  processed_count_q;
  logic [23:0]  tail_count_q;

  logic [1:0]   fifo_len;
  logic [23:0]  fifo_num;
  logic [43:0]  fifo_ts;
  logic         unused_fifo_bits;

  logic         pop;
  logic         num_mismatch;
  logic [4:0]   done_now;
  logic         all_done;
  logic         timeout_hit;
  logic [4:0]   missing;

  assign fifo_ts          = trig_fifo_data[43:0];
  assign fifo_num         = trig_fifo_data[67:44];
  assign fifo_len         = trig_fifo_data[69:68];
  assign unused_fifo_bits = ^trig_fifo_data[127:70];

  // Held low during reset so nothing is popped while the block is being cleared.
  assign trig_fifo_ready = state_q[0] & ~reset;
  assign pop             = trig_fifo_valid & trig_fifo_ready;
  assign num_mismatch    = (fifo_num != expected_num_q);
  assign done_now        = chan_done & en_q;
  assign all_done        = ((done_mask_q | done_now) == en_q);
  assign missing         = en_q & ~done_mask_q;

  assign state           = state_q;
  assign seq_error_count = seq_error_count_q;
  assign processed_count = processed_count_q;

`ifdef PULSE_TRIG_PROC_TIMEOUT_EN
  logic [15:0] timer_q;
  logic [31:0] timeout_count_q;

  // Completion in the timeout cycle wins, so the record goes out clean.
  assign timeout_hit   = (state_q == StWaitChan) && (timer_q == TIMEOUT_CYCLES) && !all_done;
  assign timeout_count = timeout_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q         <= 16'd0;
      timeout_count_q <= 32'd0;
    end else begin
      if (pop) begin
        timer_q <= 16'd0;
      end else if (state_q == StWaitChan && timer_q != 16'hFFFF) begin
        timer_q <= timer_q + 16'd1;
      end
      if (timeout_hit && timeout_count_q != 32'hFFFF_FFFF) begin
        timeout_count_q <= timeout_count_q + 32'd1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign timeout_count      = 32'd0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pop) state_d = StWaitChan;
      end
      StWaitChan: begin
        if (all_done || timeout_hit) state_d = StSendHdr;
      end
      StSendHdr: begin
        if (info_ready) state_d = StSendTail;
      end
      StSendTail: begin
        if (info_ready) state_d = StIdle;
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    info_valid = 1'b0;
    info_last  = 1'b0;
    info_data  = 64'd0;
    if (state_q == StSendHdr) begin
      info_valid = 1'b1;
      info_data  = {4'hA, len_q, en_q, missing, 4'h0, ts_q};
    end else if (state_q == StSendTail) begin
      info_valid = 1'b1;
      info_last  = 1'b1;
      info_data  = {seq_err_q, timeout_q, 14'd0, num_q, tail_count_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= StIdle;
      len_q             <= 2'd0;
      num_q             <= 24'd0;
      ts_q              <= 44'd0;
      en_q              <= 5'd0;
      done_mask_q       <= 5'd0;
      seq_err_q         <= 1'b0;
      timeout_q         <= 1'b0;
      expected_num_q    <= 24'd1;
      seq_error_count_q <= 32'd0;
      processed_count_q <= 24'd0;
      tail_count_q      <= 24'd0;
    end else begin
      state_q <= state_d;

      if (pop) begin
        len_q       <= fifo_len;
        num_q       <= fifo_num;
        ts_q        <= fifo_ts;
        en_q        <= chan_en;
        seq_err_q   <= num_mismatch;
        timeout_q   <= 1'b0;
        done_mask_q <= 5'd0;
      end else if (state_q == StWaitChan) begin
        done_mask_q <= done_mask_q | done_now;
        if (timeout_hit) timeout_q <= 1'b1;
      end

      // A sequence reset outranks the pop update; the pop was already checked above.
      if (reset_trig_num || readout_done) begin
        expected_num_q <= 24'd1;
      end else if (pop) begin
        expected_num_q <= fifo_num + 24'd1;
      end

      if (pop && num_mismatch && seq_error_count_q != 32'hFFFF_FFFF) begin
        seq_error_count_q <= seq_error_count_q + 32'd1;
      end

      // Snapshot keeps the tail beat stable even if readout_done lands during a stall.
      if (state_q == StSendHdr && info_ready) begin
        tail_count_q <= processed_count_q;
      end

      if (readout_done) begin
        processed_count_q <= 24'd0;
      end else if (state_q == StSendTail && info_ready) begin
        processed_count_q <= processed_count_q + 24'd1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_trigger_processor.sv
// Scoreboard bench for pulse_trigger_processor: driver queues expected beats, monitor pops them.
module tb_pulse_trigger_processor;

  logic         clk = 1'b0;
  logic         reset;
  logic         reset_trig_num;
  logic         readout_done;
  logic [4:0]   chan_en;
  logic         trig_fifo_valid;
  logic [127:0] trig_fifo_data;
  logic         trig_fifo_ready;
  logic [4:0]   chan_done;
  logic         info_valid;
  logic         info_ready;
  logic [63:0]  info_data;
  logic         info_last;
  logic [4:0]   state;
  logic [31:0]  seq_error_count;
  logic [31:0]  timeout_count;
  logic [23:0]  processed_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_beats  = 0;

  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  logic [23:0] exp_num_m;
  logic [23:0] pc_m;
  int          seq_m;

  pulse_trigger_processor #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clk             (clk),
    .reset           (reset),
    .reset_trig_num  (reset_trig_num),
    .readout_done    (readout_done),
    .chan_en         (chan_en),
    .trig_fifo_valid (trig_fifo_valid),
    .trig_fifo_data  (trig_fifo_data),
    .trig_fifo_ready (trig_fifo_ready),
    .chan_done       (chan_done),
    .info_valid      (info_valid),
    .info_ready      (info_ready),
    .info_data       (info_data),
    .info_last       (info_last),
    .state           (state),
    .seq_error_count (seq_error_count),
    .timeout_count   (timeout_count),
    .processed_count (processed_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake completes on the next rising edge; inputs are settled by the falling edge.
  always @(negedge clk) begin
    if (!reset && info_valid && info_ready) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h, expected no beat", info_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_data", info_data, mon_e[63:0]);
        check("beat_last", {63'd0, info_last}, {63'd0, mon_e[64]});
      end
    end
  end

  task automatic push_trig(input logic [1:0] len, input logic [23:0] num, input logic [43:0] ts,
                           input logic [4:0] en, input logic [4:0] missing, input logic to,
                           input bit push_tail);
    logic se;
    int   b;
    se = (num != exp_num_m);
    exp_q.push_back({1'b0, 4'hA, len, en, missing, 4'h0, ts});
    if (push_tail) begin
      exp_q.push_back({1'b1, se, to, 14'd0, num, pc_m});
      pc_m = pc_m + 24'd1;
    end
    if (se) seq_m++;
    exp_num_m = num + 24'd1;
    trig_fifo_valid = 1'b1;
    trig_fifo_data  = {58'd0, len, num, ts};
    chan_en         = en;
    b = 0;
    while (!trig_fifo_ready && b < 50) begin
      tick();
      b++;
    end
    if (b == 50) check("pop_ready_timeout", 64'd0, 64'd1);
    tick();
    trig_fifo_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [4:0] m);
    chan_done = m;
    tick();
    chan_done = 5'd0;
  endtask

  task automatic wait_idle(input int budget);
    int b;
    b = 0;
    while (state != 5'b00001 && b < budget) begin
      tick();
      b++;
    end
    if (b == budget) check("wait_idle_timeout", {59'd0, state}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] hdr_exp;
    int          beats0;

    reset = 1'b1; reset_trig_num = 1'b0; readout_done = 1'b0; chan_en = 5'd0;
    trig_fifo_valid = 1'b0; trig_fifo_data = 128'd0; chan_done = 5'd0; info_ready = 1'b1;
    exp_num_m = 24'd1; pc_m = 24'd0; seq_m = 0;
    tick(); tick();

    // Reset state
    check("rst_state", {59'd0, state}, 64'd1);
    check("rst_fifo_ready", {63'd0, trig_fifo_ready}, 64'd0);
    check("rst_info_valid", {63'd0, info_valid}, 64'd0);
    check("rst_info_data", info_data, 64'd0);
    check("rst_counts", {seq_error_count, timeout_count}, 64'd0);
    check("rst_processed", {40'd0, processed_count}, 64'd0);
    reset = 1'b0;
    tick();
    check("idle_fifo_ready", {63'd0, trig_fifo_ready}, 64'd1);

    // Normal record: two channels complete at different times
    push_trig(2'b10, 24'd1, 44'h123, 5'b00101, 5'b00000, 1'b0, 1'b1);
    pulse_done(5'b00001);
    pulse_done(5'b00100);
    wait_idle(20);
    check("normal_processed", {40'd0, processed_count}, 64'd1);
    check("normal_seq_err", {32'd0, seq_error_count}, 64'd0);

    // Sequence error on the jump 2 -> 4
    push_trig(2'b00, 24'd2, 44'h200, 5'd0, 5'd0, 1'b0, 1'b1);
    wait_idle(20);
    push_trig(2'b01, 24'd4, 44'h400, 5'd0, 5'd0, 1'b0, 1'b1);
    wait_idle(20);
    check("seq_err_count", {32'd0, seq_error_count}, 64'd1);
    readout_done = 1'b1;
    tick();
    readout_done = 1'b0;
    exp_num_m = 24'd1;
    pc_m = 24'd0;
    check("readout_clear", {40'd0, processed_count}, 64'd0);
    push_trig(2'b11, 24'd1, 44'h111, 5'd0, 5'd0, 1'b0, 1'b1);
    wait_idle(20);
    check("seq_after_readout", {32'd0, seq_error_count}, {32'd0, seq_m});
    check("processed_after_readout", {40'd0, processed_count}, {40'd0, pc_m});

    // Backpressure and minimum latency with no enabled channels
    info_ready = 1'b0;
    hdr_exp = {4'hA, 2'b01, 5'd0, 5'd0, 4'h0, 44'hABCDE};
    push_trig(2'b01, 24'd2, 44'hABCDE, 5'd0, 5'd0, 1'b0, 1'b1);
    check("latency_wait", {63'd0, info_valid}, 64'd0);
    tick();
    check("latency_valid", {63'd0, info_valid}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_data", info_data, hdr_exp);
      check("bp_fifo_ready", {62'd0, trig_fifo_ready, info_last}, 64'd0);
      tick();
    end
    beats0 = n_beats;
    info_ready = 1'b1;
    wait_idle(20);
    check("bp_beats", 64'(n_beats - beats0), 64'd2);

    // Timeout: channel 1 never reports
`ifdef PULSE_TRIG_PROC_TIMEOUT_EN
    push_trig(2'b00, 24'd3, 44'h777, 5'b00011, 5'b00010, 1'b1, 1'b1);
    pulse_done(5'b00001);
    wait_idle(100);
    check("timeout_count", {32'd0, timeout_count}, 64'd1);
`else
    push_trig(2'b00, 24'd3, 44'h777, 5'b00011, 5'b00000, 1'b0, 1'b1);
    pulse_done(5'b00001);
    repeat (40) tick();
    check("no_timeout_state", {59'd0, state}, 64'd2);
    check("no_timeout_valid", {63'd0, info_valid}, 64'd0);
    pulse_done(5'b00010);
    wait_idle(20);
    check("timeout_count_zero", {32'd0, timeout_count}, 64'd0);
`endif

    // Reset while the tail beat is stalled
    info_ready = 1'b0;
    push_trig(2'b00, 24'd4, 44'h444, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    check("tail_hdr_valid", {63'd0, info_valid}, 64'd1);
    info_ready = 1'b1;
    tick();
    info_ready = 1'b0;
    check("tail_state", {59'd0, state}, 64'd8);
    reset = 1'b1;
    tick();
    check("midrst_state", {59'd0, state}, 64'd1);
    check("midrst_valid", {63'd0, info_valid}, 64'd0);
    check("midrst_counts", {seq_error_count, timeout_count}, 64'd0);
    check("midrst_processed", {40'd0, processed_count}, 64'd0);
    reset = 1'b0;
    exp_num_m = 24'd1;
    pc_m = 24'd0;
    seq_m = 0;
    info_ready = 1'b1;
    tick();
    push_trig(2'b10, 24'd1, 44'h999, 5'd0, 5'd0, 1'b0, 1'b1);
    wait_idle(20);
    check("post_rst_seq", {32'd0, seq_error_count}, 64'd0);
    check("post_rst_processed", {40'd0, processed_count}, 64'd1);

    tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
